// File: rtl/mcalu_iter_pkg.sv
// ============================================================================
// Module  : mcalu_iter_pkg
// Brief   : Shared widths, M-extension opcodes and FSM encoding for mcalu_iter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mcalu_iter_pkg;

    localparam int MC_XLEN    = 32;
    localparam int MC_ROBID_W = 7;
    localparam int MC_RD_W    = 6;

    localparam logic [4:0] MC_MUL    = 5'b11000;
    localparam logic [4:0] MC_MULH   = 5'b11001;
    localparam logic [4:0] MC_MULHSU = 5'b11010;
    localparam logic [4:0] MC_MULHU  = 5'b11011;
    localparam logic [4:0] MC_DIV    = 5'b11100;
    localparam logic [4:0] MC_DIVU   = 5'b11101;
    localparam logic [4:0] MC_REM    = 5'b11110;
    localparam logic [4:0] MC_REMU   = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mc_state_t;

endpackage

`default_nettype wire

// File: rtl/mcalu_iter_dp.sv
// ============================================================================
// Module  : mcalu_iter_dp
// Brief   : 2*XLEN shift datapath: shift-add multiply / restoring divide step.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mcalu_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_mode_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc_next
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;

    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shl;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;

    always_comb begin
        w_hi  = r_acc[2*XLEN-1:XLEN];
        w_lo  = r_acc[XLEN-1:0];
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
        // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
        w_shl = {w_hi, w_lo[XLEN-1]};
        w_ge  = (w_shl >= {1'b0, r_b});
        w_sub = XLEN'(w_shl - {1'b0, r_b});
        if (i_mode_div) begin
            if (w_ge) o_acc_next = {w_sub, w_lo[XLEN-2:0], 1'b1};
            else      o_acc_next = {w_shl[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
        end else begin
            o_acc_next = {w_sum, w_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= {{XLEN{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (i_step) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcalu_iter.sv
// ============================================================================
// Module  : mcalu_iter
// Brief   : Iterative multi-cycle M-extension ALU with writeback-bus handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mcalu_iter
    import mcalu_iter_pkg::*;
#(
    parameter int XLEN    = MC_XLEN,
    parameter int ROBID_W = MC_ROBID_W,
    parameter int RD_W    = MC_RD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exers_mcalu_issue,
    input  logic [4:0]         exers_mcalu_op,
    input  logic [ROBID_W-1:0] exers_robid,
    input  logic [RD_W-1:0]    exers_rd,
    input  logic [XLEN-1:0]    exers_op1,
    input  logic [XLEN-1:0]    exers_op2,
    output logic               mcalu_stall,
    output logic               mcalu_wb_req,
    input  logic               wb_grant,
    output logic [ROBID_W-1:0] mcalu_wb_robid,
    output logic [RD_W-1:0]    mcalu_wb_rd,
    output logic [XLEN-1:0]    mcalu_wb_result,
    output logic               mcalu_wb_error,
    input  logic               rob_flush
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

    mc_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_fn;
    logic               r_negate;
    logic [ROBID_W-1:0] r_robid;
    logic [RD_W-1:0]    r_rd;
    logic [XLEN-1:0]    r_result;
    logic               r_error;

    logic               w_accept, w_legal, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
    logic               w_negate, w_div0, w_ovf, w_bypass, w_step, w_last;
    logic [XLEN-1:0]    w_mag1, w_mag2, w_special, w_fixed;
    logic [2*XLEN-1:0]  w_next, w_prod;
    logic [XLEN-1:0]    w_q, w_r;

    assign w_accept = exers_mcalu_issue & (r_state == S_IDLE) & ~rob_flush;
    assign w_legal  = (exers_mcalu_op[4:3] == 2'b11);
    assign w_is_div = exers_mcalu_op[2];

    always_comb begin
        // Signedness: MULH s*s, MULHSU s*u, DIV/REM s*s; MUL low half is sign-agnostic.
        if (w_is_div) begin
            w_s1 = ~exers_mcalu_op[0];
            w_s2 = ~exers_mcalu_op[0];
        end else begin
            w_s1 = (exers_mcalu_op[1:0] == 2'b01) | (exers_mcalu_op[1:0] == 2'b10);
            w_s2 = (exers_mcalu_op[1:0] == 2'b01);
        end
        w_neg1   = w_s1 & exers_op1[XLEN-1];
        w_neg2   = w_s2 & exers_op2[XLEN-1];
        w_mag1   = w_neg1 ? -exers_op1 : exers_op1;
        w_mag2   = w_neg2 ? -exers_op2 : exers_op2;
        w_negate = (w_is_div & exers_mcalu_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

        w_div0 = w_is_div & (exers_op2 == '0);
        w_ovf  = w_is_div & ~exers_mcalu_op[0] & (exers_op2 == '1)
               & (exers_op1 == {1'b1, {(XLEN-1){1'b0}}});
        if (!w_legal)            w_special = '0;
        else if (w_div0)         w_special = exers_mcalu_op[1] ? exers_op1 : '1;
        else                     w_special = exers_mcalu_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        w_bypass = ~w_legal | w_div0 | w_ovf;
    end

    assign w_step = (r_state == S_MUL) | (r_state == S_DIV);
    assign w_last = w_step & (r_cnt == C_LAST);

    mcalu_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_mode_div (r_state == S_DIV),
        .i_a        (w_mag1),
        .i_b        (w_mag2),
        .o_acc_next (w_next)
    );

    always_comb begin
        w_prod = r_negate ? -w_next : w_next;
        w_q    = r_negate ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
        w_r    = r_negate ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];
        if (r_fn[2])                 w_fixed = r_fn[1] ? w_r : w_q;
        else if (r_fn[1:0] == 2'b00) w_fixed = w_prod[XLEN-1:0];
        else                         w_fixed = w_prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_bypass ? S_DONE : (w_is_div ? S_DIV : S_MUL);
            S_MUL,
            S_DIV:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (mcalu_wb_req && wb_grant) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (rob_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_fn     <= '0;
            r_negate <= 1'b0;
            r_robid  <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_fn     <= exers_mcalu_op[2:0];
            r_negate <= w_negate;
            r_robid  <= exers_robid;
            r_rd     <= exers_rd;
            r_result <= w_special;
            r_error  <= ~w_legal;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= w_fixed;
        end
    end

    assign mcalu_stall     = (r_state != S_IDLE);
    assign mcalu_wb_req    = (r_state == S_DONE) & ~rob_flush;
    assign mcalu_wb_robid  = r_robid;
    assign mcalu_wb_rd     = r_rd;
    assign mcalu_wb_result = r_result;
    assign mcalu_wb_error  = r_error;

    a_no_issue_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(exers_mcalu_issue && r_state != S_IDLE));

endmodule

`default_nettype wire

// File: tb/tb_mcalu_iter.sv
// ============================================================================
// Module  : tb_mcalu_iter
// Brief   : Directed self-checking bench for mcalu_iter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mcalu_iter;
    import mcalu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue = 1'b0;
    logic [4:0]  op = '0;
    logic [6:0]  robid = '0;
    logic [5:0]  rd = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        wb_grant = 1'b0;
    logic        rob_flush = 1'b0;
    logic        stall, wb_req, wb_error;
    logic [6:0]  wb_robid;
    logic [5:0]  wb_rd;
    logic [31:0] wb_result;

    int n_err = 0;
    int n_chk = 0;

    mcalu_iter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exers_mcalu_issue (issue),
        .exers_mcalu_op    (op),
        .exers_robid       (robid),
        .exers_rd          (rd),
        .exers_op1         (op1),
        .exers_op2         (op2),
        .mcalu_stall       (stall),
        .mcalu_wb_req      (wb_req),
        .wb_grant          (wb_grant),
        .mcalu_wb_robid    (wb_robid),
        .mcalu_wb_rd       (wb_rd),
        .mcalu_wb_result   (wb_result),
        .mcalu_wb_error    (wb_error),
        .rob_flush         (rob_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the caller at the negedge of cycle T+1.
    task automatic do_issue(input logic [4:0] o, input logic [6:0] id, input logic [5:0] d,
                            input logic [31:0] a, input logic [31:0] b);
        issue = 1'b1; op = o; robid = id; rd = d; op1 = a; op2 = b;
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic wait_req(output int lat);
        lat = 1;
        while (!wb_req && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic grant_and_idle(input string tag);
        wb_grant = 1'b1;
        @(negedge clk);
        wb_grant = 1'b0;
        check({tag, "_idle"}, stall, 0);
    endtask

    task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        do_issue(o, 7'h01, 6'h01, a, b);
        wait_req(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, wb_result, exp_res);
        check({tag, "_err"}, wb_error, 0);
        grant_and_idle(tag);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] held;

        repeat (2) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_req", wb_req, 0);
        check("rst_robid", wb_robid, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_result", wb_result, 0);
        check("rst_error", wb_error, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_issue(MC_MUL, 7'h15, 6'd3, 32'd7, 32'd6);
        check("mul_stall_t1", stall, 1);
        check("mul_req_t1", wb_req, 0);
        wait_req(lat);
        check("mul_lat", lat, 33);
        check("mul_res", wb_result, 32'h0000002A);
        check("mul_robid", wb_robid, 7'h15);
        check("mul_rd", wb_rd, 3);
        check("mul_err", wb_error, 0);
        check("mul_stall_done", stall, 1);
        grant_and_idle("mul");

        run("mulh",   MC_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000);
        run("mulhu",  MC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
        run("mulhsu", MC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF);
        run("mulneg", MC_MUL,    32'hFFFFFFFD, 32'd5,        33, 32'hFFFFFFF1);
        run("div",    MC_DIV,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
        run("rem",    MC_REM,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
        run("divu",   MC_DIVU,   32'hFFFFFFF9, 32'd2,        33, 32'h7FFFFFFC);
        run("remu",   MC_REMU,   32'd100,      32'd7,        33, 32'd2);
        run("divu0",  MC_DIVU,   32'h12345678, 32'd0,        1,  32'hFFFFFFFF);
        run("remu0",  MC_REMU,   32'h12345678, 32'd0,        1,  32'h12345678);
        run("removf", MC_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'h00000000);
        run("divovf", MC_DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);

        // Grant withheld: writeback must hold, then a new op follows immediately.
        do_issue(MC_MULHU, 7'h2A, 6'd9, 32'h00010000, 32'h00030000);
        wait_req(lat);
        check("hold_lat", lat, 33);
        held = wb_result;
        check("hold_res0", held, 32'h00000003);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res", wb_result, 32'h00000003);
            check("hold_req", wb_req, 1);
            check("hold_stall", stall, 1);
        end
        grant_and_idle("hold");
        do_issue(5'b00101, 7'h33, 6'd4, 32'd1, 32'd2);
        wait_req(lat);
        check("illegal_lat", lat, 1);
        check("illegal_err", wb_error, 1);
        check("illegal_res", wb_result, 0);
        check("illegal_robid", wb_robid, 7'h33);
        grant_and_idle("illegal");

        // Flush mid-operation drops the op without a writeback.
        do_issue(MC_MUL, 7'h11, 6'd5, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rob_flush = 1'b1;
        check("flush_req", wb_req, 0);
        @(negedge clk);
        rob_flush = 1'b0;
        check("flush_stall", stall, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (wb_req) seen = 1'b1;
        end
        check("flush_noreq", seen, 0);

        // Issue coinciding with flush is not accepted.
        issue = 1'b1; op = MC_MUL; rob_flush = 1'b1;
        @(negedge clk);
        issue = 1'b0; rob_flush = 1'b0;
        check("flushiss_stall", stall, 0);

        // No-destination result is still written back, then reset clears it.
        do_issue(MC_MUL, 7'h55, 6'h20, 32'd3, 32'd4);
        wait_req(lat);
        check("nodst_rd", wb_rd, 6'h20);
        check("nodst_res", wb_result, 32'd12);
        rst_n = 1'b0;
        #1;
        check("arst_req", wb_req, 0);
        check("arst_stall", stall, 0);
        check("arst_robid", wb_robid, 0);
        check("arst_rd", wb_rd, 0);
        check("arst_result", wb_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_issue(MC_MUL, 7'h66, 6'd7, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_robid", wb_robid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("postrst", MC_MUL, 32'd11, 32'd13, 33, 32'd143);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcalu_iter.md
Name: mcalu_iter

Overview:
Multi-cycle ALU that consumes one reservation-station issue port (the mcalu side of the exec RS) and returns results on the shared writeback bus. It executes the M-extension ops encoded with op[4:3]==2'b11. Multiply is iterative shift-add; divide is iterative restoring. The unit holds one op at a time, and the finished result waits for a writeback-bus grant.

Parameters:
XLEN, 32, operand/result width
ROBID_W, 7, ROB tag width
RD_W, 6, destination width; rd[5]=1 means no architectural destination

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
exers_mcalu_issue  input  1  issue strobe from RS
exers_mcalu_op  input  5  opcode
exers_robid  input  ROBID_W  tag of issued op
exers_rd  input  RD_W  destination of issued op
exers_op1  input  XLEN  operand 1 (rs1)
exers_op2  input  XLEN  operand 2 (rs2)
mcalu_stall  output  1  busy; RS must not issue
mcalu_wb_req  output  1  result pending, requests writeback bus
wb_grant  input  1  bus grant; a transfer occurs when req&grant
mcalu_wb_robid  output  ROBID_W  result tag
mcalu_wb_rd  output  RD_W  result destination
mcalu_wb_result  output  XLEN  result data
mcalu_wb_error  output  1  illegal opcode flag
rob_flush  input  1  pipeline flush

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mcalu_stall=0; mcalu_wb_req=0.
  - wb robid/rd/result/error=0.
  - Reset mid-operation discards the op.
- States: IDLE, MUL, DIV, DONE. mcalu_stall = (state!=IDLE), registered-state only, with no combinational path from issue.
- Accept: in IDLE with exers_mcalu_issue=1, latch op/robid/rd/operands at the edge (cycle T).
  - If rob_flush is high in the same cycle, do not accept.
  - An issue while stalled is a protocol violation: ignore it and fire an assertion.
- Opcodes:
  - 11000 MUL (low 32), 11001 MULH (s*s high), 11010 MULHSU (s*u high), 11011 MULHU (u*u high).
  - 11100 DIV, 11101 DIVU, 11110 REM, 11111 REMU.
  - Any op with op[4:3]!=11: go to DONE at T+1 with error=1 and result=0.
- Sign handling: signed operands are converted to magnitude at accept, and a negate flag is recorded.
  - Negate applies to the 64-bit product, to the quotient (signs differ), or to the remainder (dividend sign).
  - Sign fixup is applied on the transition into DONE.
- Iteration: a 5-bit counter runs 32 iterations, in cycles T+1..T+32. DONE with wb_req=1 occurs from T+33.
- Divide special cases bypass iteration and reach DONE at T+1:
  - Divisor 0: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed 0x80000000/-1: quotient=0x80000000, remainder=0.
- DONE: wb outputs hold stable while req=1 and grant=0. On req&grant the unit goes to IDLE at the next edge, so throughput is ≥1 op per 34 cycles.
- wb_req = (state==DONE) & ~rob_flush.
- rob_flush at any state: go to IDLE next edge and drop the pending result. Flush with grant in the same cycle means no transfer.
- Results with rd[5]=1 are still written back, because the ROB needs completion.

Decomposition:
- Shared package: opcode localparams (MC_MUL..MC_REMU), the state encoding, and XLEN/ROBID_W/RD_W defaults shared with the RS.
- One sub-module, mcalu_iter_dp: the 64-bit accumulator/remainder shift datapath with a step enable and a mode input (mul/div).
- The FSM, sign fixup and writeback hold live in the top module.

Test Plan:
- MUL 7*6, robid=0x15, rd=3 -> wb_req rises at T+33, result=0x0000002A, robid=0x15, rd=3, error=0; stall high T+1..until granted.
- MULH/MULHU with op1=op2=0xFFFFFFFF -> MULH result=0x00000000, MULHU result=0xFFFFFFFE, MULHSU result=0xFFFFFFFF.
- DIV/REM with op1=0xFFFFFFF9 (-7), op2=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF; DIVU same operands=0x7FFFFFFC.
- DIVU op2=0 -> wb_req at T+1, result=0xFFFFFFFF; REM 0x80000000 % 0xFFFFFFFF -> T+1, result=0.
- Grant withheld 5 cycles after DONE -> outputs stable, stall=1; grant -> IDLE next cycle; new issue accepted the following cycle.
- rob_flush at T+10 -> no wb_req ever, stall=0 at T+11. rst_n pulsed mid-op -> all outputs 0 immediately. Op 5'b00101 -> error=1 at T+1.
